// File: rtl/snd_dma_addr.sv
// Sound DMA address stage.
//
// Holds the CPU-programmed frame start/end registers and runs the word address
// counter that feeds the MCU control block. The counter advances once per sound
// load strobe; at frame end it either reloads (repeat mode) or stops.
//
// Ports:
//   clk32      system clock, all state changes on the rising edge
//   por        synchronous active-high reset
//   reg_wr     one-cycle CPU register write strobe
//   reg_rd     one-cycle CPU register read strobe
//   reg_idx    register select: 0-2 start H/M/L, 3-5 counter H/M/L, 6-8 end H/M/L
//   din        CPU write data
//   dout       CPU read data (registered, holds between reads)
//   sndon      DMA enable bit
//   sfrep      repeat mode
//   sload      one-cycle enable per fetched sound word
//   snd        current word address (byte address bits 21:1)
//   sft        active (shadowed) frame end address
//   frame_end  one-cycle pulse when a frame completes
//   stop       one-cycle pulse requesting the enable bit be cleared
//   running    high while the counter is running
//
// Build option: define SND_CNT_READ_EN to make the counter readable at
// indices 3-5; otherwise those indices read as zero.
//
// Only the frame end needs a shadow copy: frame begin and reload always take
// the live start register, so a start shadow would have no consumer.

module snd_dma_addr #(
  parameter int unsigned     AW         = 21,
  parameter logic [AW-1:0]   RESET_ADDR = '0
) (
  input  logic          clk32,
  input  logic          por,
  input  logic          reg_wr,
  input  logic          reg_rd,
  input  logic [3:0]    reg_idx,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic          sndon,
  input  logic          sfrep,
  input  logic          sload,
  output logic [AW-1:0] snd,
  output logic [AW-1:0] sft,
  output logic          frame_end,
  output logic          stop,
  output logic          running
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW-1:0] end_sh_q, end_sh_d;
  logic [AW-1:0] snd_q, snd_d;
  logic [7:0]    dout_q, dout_d;
  logic          frame_end_q, frame_end_d;
  logic          stop_q, stop_d;
  logic          sndon_q;
  logic [7:0]    rd_data;

  // Byte lanes are defined on the byte address: H = [21:16], M = [15:8], L = [7:1].
  function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] addr,
                                              input logic [1:0]    sel,
                                              input logic [7:0]    data);
    logic [23:0] b;
    b       = '0;
    b[AW:1] = addr;
    case (sel)
      2'd0:    b[21:16] = data[5:0];
      2'd1:    b[15:8]  = data;
      default: b[7:1]   = data[7:1];
    endcase
    return b[AW:1];
  endfunction

  function automatic logic [7:0] get_byte(input logic [AW-1:0] addr, input logic [1:0] sel);
    logic [23:0] b;
    b       = '0;
    b[AW:1] = addr;
    case (sel)
      2'd0:    return {2'b00, b[21:16]};
      2'd1:    return b[15:8];
      default: return {b[7:1], 1'b0};
    endcase
  endfunction

  // CPU register writes; counter and undefined indices are not writable.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    if (reg_wr) begin
      case (reg_idx)
        4'd0, 4'd1, 4'd2: start_d = put_byte(start_q, reg_idx[1:0], din);
        4'd6:             end_d   = put_byte(end_q, 2'd0, din);
        4'd7:             end_d   = put_byte(end_q, 2'd1, din);
        4'd8:             end_d   = put_byte(end_q, 2'd2, din);
        default: ;
      endcase
    end
  end

  // CPU read mux.
  always_comb begin
    rd_data = 8'h00;
    case (reg_idx)
      4'd0, 4'd1, 4'd2: rd_data = get_byte(start_q, reg_idx[1:0]);
`ifdef SND_CNT_READ_EN
      4'd3:             rd_data = get_byte(snd_q, 2'd0);
      4'd4:             rd_data = get_byte(snd_q, 2'd1);
      4'd5:             rd_data = get_byte(snd_q, 2'd2);
`endif
      4'd6:             rd_data = get_byte(end_q, 2'd0);
      4'd7:             rd_data = get_byte(end_q, 2'd1);
      4'd8:             rd_data = get_byte(end_q, 2'd2);
      default: ;
    endcase
    dout_d = reg_rd ? rd_data : dout_q;
  end

  // Counter state machine. Frame begin and reload read start_q/end_q before any
  // same-cycle CPU write lands, so a write takes effect at the next frame begin.
  always_comb begin
    state_d     = state_q;
    snd_d       = snd_q;
    end_sh_d    = end_sh_q;
    frame_end_d = 1'b0;
    stop_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (sndon && !sndon_q) state_d = StLoad;
      end
      StLoad: begin
        snd_d    = start_q;
        end_sh_d = end_q;
        state_d  = StRun;
      end
      StRun: begin
        if (!sndon) begin
          state_d = StIdle;
        end else if (sload) begin
          if (snd_q != end_sh_q) begin
            snd_d = snd_q + 1'b1;
          end else if (sfrep) begin
            snd_d       = start_q;
            end_sh_d    = end_q;
            frame_end_d = 1'b1;
          end else begin
            frame_end_d = 1'b1;
            stop_d      = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk32) begin
    // Tracks the raw input even in reset so edge detection means "previous cycle".
    sndon_q <= sndon;
    if (por) begin
      state_q     <= StIdle;
      start_q     <= RESET_ADDR;
      end_q       <= RESET_ADDR;
      end_sh_q    <= RESET_ADDR;
      snd_q       <= RESET_ADDR;
      dout_q      <= 8'h00;
      frame_end_q <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      end_q       <= end_d;
      end_sh_q    <= end_sh_d;
      snd_q       <= snd_d;
      dout_q      <= dout_d;
      frame_end_q <= frame_end_d;
      stop_q      <= stop_d;
    end
  end

  assign dout      = dout_q;
  assign snd       = snd_q;
  assign sft       = end_sh_q;
  assign frame_end = frame_end_q;
  assign stop      = stop_q;
  assign running   = (state_q == StRun);

endmodule
